// File: rtl/if_fetch.sv
// Instruction-fetch stage: assembles a 32-bit little-endian instruction from four
// byte reads and presents it to decode under a valid/ready handshake.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_ack_i,
   input  logic [7:0]  mem_data_i,
   output logic        inst_valid_o,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   input  logic        id_ready_i,
   input  logic        br_en_i,
   input  logic [31:0] br_target_i
);

   typedef enum logic {S_FETCH, S_HOLD} state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_pc, w_pc_nxt;
   logic [1:0]  r_cnt, w_cnt_nxt;
   logic        r_req, w_req_nxt;
   logic [31:0] r_addr;
   logic        r_valid, w_valid_nxt;
   logic [31:0] r_pc_o, w_pc_o_nxt;
   logic [31:0] r_inst, w_inst_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_FETCH;
         r_pc    <= RESET_PC;
         r_cnt   <= 2'd0;
         r_req   <= 1'b0;
         r_addr  <= {RESET_PC[31:2], 2'b00};
         r_valid <= 1'b0;
         r_pc_o  <= 32'd0;
         r_inst  <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_cnt   <= w_cnt_nxt;
         r_req   <= w_req_nxt;
         r_addr  <= {w_pc_nxt[31:2], w_cnt_nxt};
         r_valid <= w_valid_nxt;
         r_pc_o  <= w_pc_o_nxt;
         r_inst  <= w_inst_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_cnt_nxt   = r_cnt;
      w_req_nxt   = r_req;
      w_valid_nxt = r_valid;
      w_pc_o_nxt  = r_pc_o;
      w_inst_nxt  = r_inst;

      // Redirect beats both a coinciding ack and a coinciding transfer.
      if (br_en_i) begin
         w_state_nxt = S_FETCH;
         w_pc_nxt    = br_target_i & 32'hFFFF_FFFC;
         w_cnt_nxt   = 2'd0;
         w_req_nxt   = 1'b1;
         w_valid_nxt = 1'b0;
      end else begin
         case (r_state)
            S_FETCH: begin
               // Request is still low only in the first cycle out of reset.
               if (!r_req) begin
                  w_req_nxt = 1'b1;
               end else if (mem_ack_i) begin
                  w_inst_nxt[{r_cnt, 3'b000} +: 8] = mem_data_i;
                  if (r_cnt == 2'd3) begin
                     w_state_nxt = S_HOLD;
                     w_cnt_nxt   = 2'd0;
                     w_req_nxt   = 1'b0;
                     w_valid_nxt = 1'b1;
                     w_pc_o_nxt  = r_pc;
                  end else begin
                     w_cnt_nxt = r_cnt + 2'd1;
                  end
               end
            end
            S_HOLD: begin
               if (id_ready_i) begin
                  w_state_nxt = S_FETCH;
                  w_pc_nxt    = r_pc + 32'd4;
                  w_req_nxt   = 1'b1;
                  w_valid_nxt = 1'b0;
               end
            end
            default: w_state_nxt = S_FETCH;
         endcase
      end
   end

   assign mem_req_o    = r_req;
   assign mem_addr_o   = r_addr;
   assign inst_valid_o = r_valid;
   assign pc_o         = r_pc_o;
   assign inst_o       = r_inst;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: transaction-level fetch model plus directed
// scenarios (zero-wait, random wait, hold, redirect, async reset, pc wrap).
module tb_if_fetch;

   localparam logic [31:0] PC0 = 32'h0000_0000;
   localparam logic [31:0] PC1 = 32'hFFFF_FFFC;

   logic        clk, rst_n;
   logic        mem_req, mem_ack, inst_valid, id_ready, br_en;
   logic [31:0] mem_addr, pc_o, inst_o, br_target;
   logic [7:0]  mem_data;
   logic        req1, ack1, valid1;
   logic [31:0] addr1, pc1, inst1;
   logic [7:0]  data1;

   logic [7:0]  mem [256];
   int          n_chk = 0, n_fail = 0;
   int          max_dly = 0, wcnt = 0;
   bit          pend = 0, spur = 0;
   logic [31:0] ack_q[$], q1[$];

   // transaction-level model state for the main instance
   logic [31:0] m_pc;
   logic [1:0]  m_k;
   logic        m_hold, m_started;

   if_fetch #(.RESET_PC(PC0)) dut (
      .clk(clk), .rst_n(rst_n), .mem_req_o(mem_req), .mem_addr_o(mem_addr),
      .mem_ack_i(mem_ack), .mem_data_i(mem_data), .inst_valid_o(inst_valid),
      .pc_o(pc_o), .inst_o(inst_o), .id_ready_i(id_ready), .br_en_i(br_en),
      .br_target_i(br_target));

   if_fetch #(.RESET_PC(PC1)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .mem_req_o(req1), .mem_addr_o(addr1),
      .mem_ack_i(ack1), .mem_data_i(data1), .inst_valid_o(valid1),
      .pc_o(pc1), .inst_o(inst1), .id_ready_i(1'b1), .br_en_i(1'b0),
      .br_target_i(32'd0));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] word_at(input logic [31:0] a);
      logic [7:0] i0, i1, i2, i3;
      i0 = a[7:0];
      i1 = i0 + 8'd1;
      i2 = i0 + 8'd2;
      i3 = i0 + 8'd3;
      return {mem[i3], mem[i2], mem[i1], mem[i0]};
   endfunction

   task automatic wait_valid(input string nm, input int lim);
      bit got = 0;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk); #1;
         if (inst_valid) begin
            got = 1;
            break;
         end
      end
      n_chk++;
      if (!got) begin
         n_fail++;
         $display("FAIL %s: inst_valid got 0 expected 1 within %0d cycles", nm, lim);
      end
   endtask

   // Memory responders: main one with optional random wait and spurious acks.
   always @(negedge clk) begin
      if (mem_req) begin
         if (!pend) begin
            pend = 1;
            wcnt = (max_dly == 0) ? 0 : int'($urandom_range(0, max_dly));
         end
         if (wcnt == 0) begin
            mem_ack  = 1'b1;
            mem_data = mem[mem_addr[7:0]];
            pend     = 0;
            ack_q.push_back(mem_addr);
         end else begin
            mem_ack  = 1'b0;
            mem_data = 8'hEE;
            wcnt--;
         end
      end else begin
         mem_ack  = spur;
         mem_data = 8'hEE;
         pend     = 0;
      end
   end

   always @(negedge clk) begin
      ack1  = req1;
      data1 = mem[addr1[7:0]];
      if (req1) q1.push_back(addr1);
   end

   // Model: which pc is being fetched, how many bytes are in, whether it is held.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc      <= PC0;
         m_k       <= 2'd0;
         m_hold    <= 1'b0;
         m_started <= 1'b0;
      end else if (br_en) begin
         m_pc      <= br_target & ~32'd3;
         m_k       <= 2'd0;
         m_hold    <= 1'b0;
         m_started <= 1'b1;
      end else if (!m_hold) begin
         if (!m_started) m_started <= 1'b1;
         else if (mem_ack) begin
            if (m_k == 2'd3) begin
               m_hold <= 1'b1;
               m_k    <= 2'd0;
            end else begin
               m_k <= m_k + 2'd1;
            end
         end
      end else if (id_ready) begin
         m_hold <= 1'b0;
         m_pc   <= m_pc + 32'd4;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("req", 32'(mem_req), 32'(m_started && !m_hold));
         if (m_started && !m_hold) chk("addr", mem_addr, m_pc + 32'(m_k));
         chk("valid", 32'(inst_valid), 32'(m_hold));
         if (m_hold) begin
            chk("pc_o", pc_o, m_pc);
            chk("inst_o", inst_o, word_at(m_pc));
         end
      end
   end

   initial begin
      int          first, vc;
      bit          found;
      logic [31:0] hp;

      for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
      mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'hA0; mem[3] = 8'h00;
      mem[4] = 8'h93; mem[5] = 8'h05; mem[6] = 8'h10; mem[7] = 8'h00;
      mem[252] = 8'h6F; mem[253] = 8'h00; mem[254] = 8'h00; mem[255] = 8'h00;

      rst_n = 1'b0; id_ready = 1'b1; br_en = 1'b0; br_target = 32'd0;
      mem_ack = 1'b0; mem_data = 8'd0; ack1 = 1'b0; data1 = 8'd0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_valid", 32'(inst_valid), 32'd0);
      chk("rst_pc_o", pc_o, 32'd0);
      chk("rst_inst", inst_o, 32'd0);
      ack_q.delete();
      q1.delete();
      rst_n = 1'b1;

      // zero-wait fetch from 0, latency and address order
      first = -1; vc = -1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk); #1;
         if (mem_req && first < 0) first = c;
         if (inst_valid) begin
            vc = c;
            break;
         end
      end
      chk("latency", 32'(vc - first), 32'd4);
      chk("first_inst", inst_o, 32'h00A0_0513);
      chk("first_pc", pc_o, 32'd0);
      chk("wrap_valid", 32'(valid1), 32'd1);
      chk("wrap_pc", pc1, 32'hFFFF_FFFC);
      chk("wrap_inst", inst1, 32'h0000_006F);
      wait_valid("second", 10);
      chk("second_pc", pc_o, 32'd4);
      chk("second_inst", inst_o, 32'h0010_0593);
      chk("ackq_size", 32'(ack_q.size()), 32'd8);
      if (ack_q.size() >= 8)
         for (int i = 0; i < 8; i++) chk("ack_order", ack_q[i], 32'(i));
      chk("q1_size_ge8", 32'(q1.size() >= 8), 32'd1);
      if (q1.size() >= 8) begin
         chk("q1_first", q1[0], 32'hFFFF_FFFC);
         for (int i = 0; i < 4; i++) chk("q1_wrap", q1[4 + i], 32'(i));
      end

      // random ack delays
      max_dly = 3;
      for (int n = 0; n < 3; n++) wait_valid("rand", 80);

      // hold with decode stalled, spurious acks ignored
      id_ready = 1'b0;
      spur = 1;
      hp = m_pc;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         chk("hold_req", 32'(mem_req), 32'd0);
         chk("hold_valid", 32'(inst_valid), 32'd1);
         chk("hold_pc", pc_o, hp);
         chk("hold_inst", inst_o, word_at(hp));
      end
      id_ready = 1'b1;
      @(negedge clk); #1;
      id_ready = 1'b0;
      spur = 0;
      chk("adv_req", 32'(mem_req), 32'd1);
      chk("adv_addr", mem_addr, hp + 32'd4);
      chk("adv_valid", 32'(inst_valid), 32'd0);

      // redirect coinciding with the ack of byte 2
      max_dly = 0;
      id_ready = 1'b1;
      found = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk); #1;
         if (mem_req && mem_addr[1:0] == 2'd2 && mem_ack) begin
            found = 1;
            break;
         end
      end
      chk("br_found", 32'(found), 32'd1);
      br_en = 1'b1;
      br_target = 32'h0000_0102;
      @(negedge clk); #1;
      br_en = 1'b0;
      chk("br_req", 32'(mem_req), 32'd1);
      chk("br_addr", mem_addr, 32'h0000_0100);
      chk("br_valid", 32'(inst_valid), 32'd0);
      wait_valid("br_deliver", 10);
      chk("br_pc", pc_o, 32'h0000_0100);
      chk("br_inst", inst_o, 32'h00A0_0513);

      // asynchronous reset in the middle of a fetch
      found = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk); #1;
         if (mem_req && mem_addr[1:0] == 2'd2) begin
            found = 1;
            break;
         end
      end
      chk("ar_found", 32'(found), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_req", 32'(mem_req), 32'd0);
      chk("ar_valid", 32'(inst_valid), 32'd0);
      chk("ar_pc_o", pc_o, 32'd0);
      chk("ar_inst", inst_o, 32'd0);
      @(negedge clk); #1;
      ack_q.delete();
      rst_n = 1'b1;
      found = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk); #1;
         if (ack_q.size() > 0) begin
            found = 1;
            break;
         end
      end
      chk("ar_refetch", 32'(found), 32'd1);
      if (found) chk("ar_addr0", ack_q[0], PC0);
      wait_valid("ar_deliver", 10);
      chk("ar_pc", pc_o, 32'd0);
      chk("ar_inst2", inst_o, 32'h00A0_0513);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
